// File: rtl/count_tracker.sv
// Sequence monitor for a bouncing up/down counter (MIN_VAL..MAX_VAL..MIN_VAL).
// Define COUNT_TRACKER_HOLD_EN to accept a repeated sample while locked without error.
module count_tracker #(
    parameter int WIDTH   = 3,
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 7,
    parameter int SWEEP_W = 8,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   count_in,
    input  logic               count_vld,
    input  logic               clr_cnt,
    output logic               locked,
    output logic               dir,
    output logic               peak,
    output logic               trough,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic [ERR_W-1:0]   err_cnt
);

    typedef enum logic [1:0] {
        SYNC,
        UP,
        DOWN
    } state_t;

    // One extra bit so MAX_VAL = 2^WIDTH-1 plus one does not wrap to zero.
    localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic               dir_q, dir_d;
    logic               peak_q, peak_d;
    logic               trough_q, trough_d;
    logic               err_q, err_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic [ERR_W-1:0]   errc_q, errc_d;

    logic [WIDTH:0] sample;
    logic [WIDTH:0] exp_up;
    logic [WIDTH:0] exp_dn;
    logic           hold_ok;
    logic           sweep_inc;
    logic           err_inc;

    assign sample = {1'b0, count_in};
    assign exp_up = {1'b0, last_q} + ONE_X;
    assign exp_dn = {1'b0, last_q} - ONE_X;

`ifdef COUNT_TRACKER_HOLD_EN
    assign hold_ok = (count_in == last_q);
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        dir_d     = dir_q;
        peak_d    = 1'b0;
        trough_d  = 1'b0;
        err_d     = 1'b0;
        sweep_inc = 1'b0;
        err_inc   = 1'b0;

        if (count_vld) begin
            unique case (state_q)
                SYNC: begin
                    if (sample == MIN_X) begin
                        state_d = UP;
                        dir_d   = 1'b1;
                        last_d  = count_in;
                    end else if (sample == MAX_X) begin
                        state_d = DOWN;
                        dir_d   = 1'b0;
                        last_d  = count_in;
                    end
                end
                UP: begin
                    if (hold_ok) begin
                        state_d = UP;
                    end else if (sample == exp_up && sample <= MAX_X) begin
                        last_d = count_in;
                        if (sample == MAX_X) begin
                            state_d = DOWN;
                            dir_d   = 1'b0;
                            peak_d  = 1'b1;
                        end
                    end else begin
                        state_d = SYNC;
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                DOWN: begin
                    if (hold_ok) begin
                        state_d = DOWN;
                    end else if (sample == exp_dn && sample >= MIN_X) begin
                        last_d = count_in;
                        if (sample == MIN_X) begin
                            state_d   = UP;
                            dir_d     = 1'b1;
                            trough_d  = 1'b1;
                            sweep_inc = 1'b1;
                        end
                    end else begin
                        state_d = SYNC;
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        sweep_d = sweep_q;
        errc_d  = errc_q;
        if (clr_cnt) begin
            sweep_d = '0;
            errc_d  = '0;
        end else begin
            if (sweep_inc) sweep_d = sweep_q + SWEEP_W'(1);
            if (err_inc && errc_q != '1) errc_d = errc_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            last_q   <= '0;
            dir_q    <= 1'b0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
            sweep_q  <= '0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            err_q    <= err_d;
            sweep_q  <= sweep_d;
            errc_q   <= errc_d;
        end
    end

    assign locked    = (state_q != SYNC);
    assign dir       = dir_q;
    assign peak      = peak_q;
    assign trough    = trough_q;
    assign err       = err_q;
    assign sweep_cnt = sweep_q;
    assign err_cnt   = errc_q;

endmodule

// File: tb/tb_count_tracker.sv
// Scoreboard bench for count_tracker: a behavioural model queues expected outputs per driven cycle.
module tb_count_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count_in = '0;
    logic       count_vld = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       locked, dir, peak, trough, err;
    logic [7:0] sweep_cnt, err_cnt;

`ifdef COUNT_TRACKER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    count_tracker #(.WIDTH(3), .MIN_VAL(1), .MAX_VAL(7), .SWEEP_W(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .count_vld (count_vld),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .dir       (dir),
        .peak      (peak),
        .trough    (trough),
        .err       (err),
        .sweep_cnt (sweep_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lk, dr, pk, tr, er;
        int sw, ec;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // model: ms 0=SYNC 1=UP 2=DOWN
    int ms = 0, ml = 0, msw = 0, mec = 0;
    bit md = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit r, input bit v, input int val, input bit c);
        exp_t e;
        bit pk = 0, tr = 0, er = 0, isw = 0, ier = 0;
        if (r) begin
            ms = 0; ml = 0; md = 0; msw = 0; mec = 0;
        end else begin
            if (v) begin
                if (ms == 0) begin
                    if (val == 1)      begin ms = 1; md = 1; ml = val; end
                    else if (val == 7) begin ms = 2; md = 0; ml = val; end
                end else if (HOLD && val == ml) begin
                end else if (ms == 1 && val == ml + 1) begin
                    ml = val;
                    if (val == 7) begin ms = 2; md = 0; pk = 1; end
                end else if (ms == 2 && val == ml - 1 && val >= 1) begin
                    ml = val;
                    if (val == 1) begin ms = 1; md = 1; tr = 1; isw = 1; end
                end else begin
                    ms = 0; er = 1; ier = 1;
                end
            end
            if (c) begin
                msw = 0; mec = 0;
            end else begin
                if (isw) msw = (msw + 1) % 256;
                if (ier && mec < 255) mec++;
            end
        end
        e.lk = (ms != 0); e.dr = md; e.pk = pk; e.tr = tr; e.er = er;
        e.sw = msw; e.ec = mec;
        return e;
    endfunction

    task automatic step(input bit r, input bit v, input int val, input bit c);
        exp_t e;
        @(negedge clk);
        rst = r; count_vld = v; count_in = 3'(val); clr_cnt = c;
        sb.push_back(model(r, v, val, c));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("locked", int'(locked), int'(e.lk));
        check("dir", int'(dir), int'(e.dr));
        check("peak", int'(peak), int'(e.pk));
        check("trough", int'(trough), int'(e.tr));
        check("err", int'(err), int'(e.er));
        check("sweep_cnt", int'(sweep_cnt), e.sw);
        check("err_cnt", int'(err_cnt), e.ec);
    endtask

    task automatic sample(input int val);
        step(1'b0, 1'b1, val, 1'b0);
    endtask

    task automatic reset_check();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        check("rst_locked", int'(locked), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_pulses", int'({peak, trough, err}), 0);
        check("rst_sweep", int'(sweep_cnt), 0);
        check("rst_errcnt", int'(err_cnt), 0);
    endtask

    int updn[12] = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};

    initial begin
        int g;
        bit gup;

        // single bounce
        reset_check();
        sample(1);
        check("lock_after_min", int'(locked), 1);
        check("dir_up", int'(dir), 1);
        foreach (updn[i]) begin
            sample(updn[i]);
            if (updn[i] == 7 && i == 5) check("peak_at_7", int'(peak), 1);
        end
        check("trough_end", int'(trough), 1);
        check("sweep_one", int'(sweep_cnt), 1);
        check("errcnt_zero", int'(err_cnt), 0);

        // five bounces, pulse held to one cycle with idle gaps
        reset_check();
        sample(1);
        for (int b = 0; b < 5; b++)
            foreach (updn[i]) sample(updn[i]);
        check("sweep_five", int'(sweep_cnt), 5);
        step(1'b0, 1'b0, 1, 1'b0);
        check("trough_one_cycle", int'(trough), 0);

        // UP at 3, inject 5
        sample(2); sample(3); sample(5);
        check("inj_err", int'(err), 1);
        check("inj_errcnt", int'(err_cnt), 1);
        check("inj_unlocked", int'(locked), 0);
        sample(4); sample(5);
        check("still_sync", int'(locked), 0);
        sample(7);
        check("relock_7", int'(locked), 1);
        check("relock_dir", int'(dir), 0);

        // out-of-range 0 when 1 expected, then saturate
        sample(6); sample(5); sample(4); sample(3); sample(2); sample(0);
        check("zero_err", int'(err), 1);
        for (int k = 0; k < 260; k++) begin
            sample(7); sample(5);
        end
        check("errcnt_sat", int'(err_cnt), 255);
        step(1'b0, 1'b0, 0, 1'b1);
        check("clr_errcnt", int'(err_cnt), 0);

        // repeated value while UP
        sample(1); sample(2); sample(3); sample(4); sample(4);
        check("repeat_err", int'(err), HOLD ? 0 : 1);
        sample(5);
        check("repeat_then_5", int'(locked), HOLD ? 1 : 0);

        // reset mid-sweep, then clr coinciding with trough
        reset_check();
        sample(1);
        for (int i = 0; i < 7; i++) sample(updn[i]);
        reset_check();
        sample(1);
        for (int i = 0; i < 11; i++) sample(updn[i]);
        step(1'b0, 1'b1, 1, 1'b1);
        check("clr_trough_pulse", int'(trough), 1);
        check("clr_trough_sweep", int'(sweep_cnt), 0);

        // mostly-legal random traffic
        g = 1; gup = 1;
        for (int k = 0; k < 400; k++) begin
            int val;
            bit v;
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                if (gup) begin g++; if (g == 7) gup = 0; end
                else     begin g--; if (g == 1) gup = 1; end
            end
            val = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : g;
            step(1'b0, v, val, ($urandom_range(0, 30) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
